// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// The loader takes the master side; the stream source and memory take the slave side.
interface imem_loader_if #(parameter int ADDR_WIDTH = 10);
   logic [7:0]            byte_in;
   logic                  byte_valid;
   logic                  byte_ready;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [31:0]           mem_wdata;

   modport master (
      input  byte_in, byte_valid,
      output byte_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output byte_in, byte_valid,
      input  byte_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/imem_loader.sv
// Fills instruction memory from a big-endian byte stream while holding the CPU in stall,
// then releases it with a one-cycle PC-reset pulse.
module imem_loader #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                start,
   input  logic [ADDR_WIDTH:0] word_count,
   imem_loader_if.master       bus,
   output logic                cpu_hold,
   output logic                pc_reset,
   output logic                done,
   output logic                error
);

   typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_WRITE, ST_DONE} state_t;

   localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] ONE       = {{ADDR_WIDTH{1'b0}}, 1'b1};

   state_t                state_q, state_d;
   logic [1:0]            byte_cnt_q, byte_cnt_d;
   logic [ADDR_WIDTH:0]   index_q, index_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [31:0]           word_q, word_d;
   logic [31:0]           mem_wdata_q, mem_wdata_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic                  byte_ready_q, byte_ready_d;
   logic                  mem_we_q, mem_we_d;
   logic                  cpu_hold_q, cpu_hold_d;
   logic                  pc_reset_q, pc_reset_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic                  take_start;

   always_comb begin
      take_start  = start && (state_q == ST_IDLE || state_q == ST_DONE);
      state_d     = state_q;
      byte_cnt_d  = byte_cnt_q;
      index_d     = index_q;
      count_d     = count_q;
      word_d      = word_q;
      mem_wdata_d = mem_wdata_q;
      mem_addr_d  = mem_addr_q;
      mem_we_d    = 1'b0;
      error_d     = error_q;

      if (take_start) begin
         if (word_count == '0) begin
            state_d = ST_DONE;
            error_d = 1'b0;
            index_d = '0;
         end else if (word_count > MAX_COUNT) begin
            state_d = ST_IDLE;
            error_d = 1'b1;
         end else begin
            state_d    = ST_RECV;
            error_d    = 1'b0;
            count_d    = word_count;
            index_d    = '0;
            byte_cnt_d = '0;
         end
      end else begin
         case (state_q)
            ST_RECV: begin
               if (bus.byte_valid && byte_ready_q) begin
                  word_d     = {word_q[23:0], bus.byte_in};
                  byte_cnt_d = byte_cnt_q + 2'd1;
                  // Fourth byte completes the word; stage the write for the WRITE cycle.
                  if (byte_cnt_q == 2'd3) begin
                     state_d     = ST_WRITE;
                     mem_we_d    = 1'b1;
                     mem_addr_d  = index_q[ADDR_WIDTH-1:0];
                     mem_wdata_d = word_d;
                  end
               end
            end
            ST_WRITE: begin
               index_d = index_q + ONE;
               state_d = (index_d == count_q) ? ST_DONE : ST_RECV;
            end
            default: ;
         endcase
      end

      // Status outputs follow the next state so they are registered yet aligned with it.
      byte_ready_d = (state_d == ST_RECV);
      cpu_hold_d   = (state_d != ST_DONE);
      done_d       = (state_d == ST_DONE);
      pc_reset_d   = (state_d == ST_DONE) && (state_q != ST_DONE || take_start);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= ST_IDLE;
         byte_cnt_q   <= '0;
         index_q      <= '0;
         count_q      <= '0;
         word_q       <= '0;
         mem_wdata_q  <= '0;
         mem_addr_q   <= '0;
         byte_ready_q <= 1'b0;
         mem_we_q     <= 1'b0;
         cpu_hold_q   <= 1'b1;
         pc_reset_q   <= 1'b0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         index_q      <= index_d;
         count_q      <= count_d;
         word_q       <= word_d;
         mem_wdata_q  <= mem_wdata_d;
         mem_addr_q   <= mem_addr_d;
         byte_ready_q <= byte_ready_d;
         mem_we_q     <= mem_we_d;
         cpu_hold_q   <= cpu_hold_d;
         pc_reset_q   <= pc_reset_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   assign bus.byte_ready = byte_ready_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign cpu_hold       = cpu_hold_q;
   assign pc_reset       = pc_reset_q;
   assign done           = done_q;
   assign error          = error_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a 4-word memory; writes and pc_reset pulses are
// logged with their cycle numbers and checked against hand-computed expectations.
module tb_imem_loader;
   localparam int AW = 2;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          start;
   logic [AW:0]   word_count;
   logic          cpu_hold, pc_reset, done, error;

   imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

   imem_loader #(.ADDR_WIDTH(AW)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .start      (start),
      .word_count (word_count),
      .bus        (bus),
      .cpu_hold   (cpu_hold),
      .pc_reset   (pc_reset),
      .done       (done),
      .error      (error)
   );

   always #5 CLK = ~CLK;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   logic [AW-1:0] wr_addr[$];
   logic [31:0]   wr_data[$];
   int            wr_cyc[$];
   int            pc_cyc[$];

   always @(posedge CLK) cyc <= cyc + 1;

   // Log every memory write and pc_reset pulse mid-cycle.
   always @(negedge CLK) begin
      if (bus.mem_we) begin
         wr_addr.push_back(bus.mem_addr);
         wr_data.push_back(bus.mem_wdata);
         wr_cyc.push_back(cyc);
      end
      if (pc_reset) pc_cyc.push_back(cyc);
   end

   task automatic clear_log();
      wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); pc_cyc.delete();
   endtask

   task automatic do_reset();
      RESET = 1'b1; start = 1'b0; bus.byte_valid = 1'b0;
      repeat (2) @(negedge CLK);
      RESET = 1'b0;
   endtask

   task automatic pulse_start(input logic [AW:0] wc, output int c0);
      start = 1'b1; word_count = wc;
      @(negedge CLK);
      start = 1'b0;
      c0 = cyc;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit ok = 1'b0;
      bus.byte_valid = 1'b0;
      repeat (gap) @(negedge CLK);
      bus.byte_in = b; bus.byte_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         ok = bus.byte_ready;
         @(negedge CLK);
      end
      bus.byte_valid = 1'b0;
      if (!ok) begin
         vectors++; miscompares++;
         $display("[TB] FAIL byte_accept: byte %h not accepted, got ready=0, expected ready=1", b);
      end
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8], gap);
   endtask

   task automatic wait_done(input int budget);
      bit seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         if (done) seen = 1'b1;
         else @(negedge CLK);
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("[TB] FAIL wait_done: got done=0 after %0d cycles, expected done=1", budget);
      end
   endtask

   task automatic test_reset();
      do_reset();
      vectors++; if (bus.byte_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_byte_ready: got %b expected 0", bus.byte_ready); end
      vectors++; if (bus.mem_we !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_mem_we: got %b expected 0", bus.mem_we); end
      vectors++; if (bus.mem_addr !== '0) begin miscompares++; $display("[TB] FAIL rst_mem_addr: got %h expected 0", bus.mem_addr); end
      vectors++; if (bus.mem_wdata !== 32'h0) begin miscompares++; $display("[TB] FAIL rst_mem_wdata: got %h expected 0", bus.mem_wdata); end
      vectors++; if (cpu_hold !== 1'b1) begin miscompares++; $display("[TB] FAIL rst_cpu_hold: got %b expected 1", cpu_hold); end
      vectors++; if (pc_reset !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_pc_reset: got %b expected 0", pc_reset); end
      vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_done: got %b expected 0", done); end
      vectors++; if (error !== 1'b0) begin miscompares++; $display("[TB] FAIL rst_error: got %b expected 0", error); end
   endtask

   task automatic test_two_word();
      int c0;
      do_reset(); clear_log();
      pulse_start(3'd2, c0);
      send_word(32'h2008_0001, 0);
      send_word(32'h2008_0002, 0);
      wait_done(20);
      @(negedge CLK);
      vectors++; if (wr_addr.size() !== 2) begin miscompares++; $display("[TB] FAIL two_nwrites: got %0d expected 2", wr_addr.size()); end
      vectors++; if (wr_addr[0] !== 2'd0 || wr_data[0] !== 32'h2008_0001) begin miscompares++; $display("[TB] FAIL two_w0: got %h@%h expected 20080001@0", wr_data[0], wr_addr[0]); end
      vectors++; if (wr_addr[1] !== 2'd1 || wr_data[1] !== 32'h2008_0002) begin miscompares++; $display("[TB] FAIL two_w1: got %h@%h expected 20080002@1", wr_data[1], wr_addr[1]); end
      vectors++; if (wr_cyc[0] !== c0 + 4 || wr_cyc[1] !== c0 + 9) begin miscompares++; $display("[TB] FAIL two_wtiming: got %0d,%0d expected %0d,%0d", wr_cyc[0], wr_cyc[1], c0 + 4, c0 + 9); end
      vectors++; if (pc_cyc.size() !== 1 || pc_cyc[0] !== c0 + 10) begin miscompares++; $display("[TB] FAIL two_pc_reset: got %0d pulses first at %0d, expected 1 at %0d", pc_cyc.size(), pc_cyc[0], c0 + 10); end
      vectors++; if (done !== 1'b1 || cpu_hold !== 1'b0 || pc_reset !== 1'b0 || bus.byte_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL two_done_state: got done=%b hold=%b pcr=%b rdy=%b expected 1 0 0 0", done, cpu_hold, pc_reset, bus.byte_ready); end
   endtask

   task automatic test_gaps();
      int c0;
      clear_log();
      pulse_start(3'd2, c0);
      vectors++; if (cpu_hold !== 1'b1 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL gap_restart: got hold=%b done=%b expected 1 0", cpu_hold, done); end
      send_word(32'h2008_0001, 3);
      send_word(32'h2008_0002, 3);
      wait_done(40);
      @(negedge CLK);
      vectors++; if (wr_addr.size() !== 2) begin miscompares++; $display("[TB] FAIL gap_nwrites: got %0d expected 2", wr_addr.size()); end
      vectors++; if (wr_addr[0] !== 2'd0 || wr_data[0] !== 32'h2008_0001) begin miscompares++; $display("[TB] FAIL gap_w0: got %h@%h expected 20080001@0", wr_data[0], wr_addr[0]); end
      vectors++; if (wr_addr[1] !== 2'd1 || wr_data[1] !== 32'h2008_0002) begin miscompares++; $display("[TB] FAIL gap_w1: got %h@%h expected 20080002@1", wr_data[1], wr_addr[1]); end
      vectors++; if (wr_cyc[0] !== c0 + 16 || wr_cyc[1] !== c0 + 32) begin miscompares++; $display("[TB] FAIL gap_wtiming: got %0d,%0d expected %0d,%0d", wr_cyc[0], wr_cyc[1], c0 + 16, c0 + 32); end
      vectors++; if (pc_cyc.size() !== 1 || pc_cyc[0] !== c0 + 33) begin miscompares++; $display("[TB] FAIL gap_pc_reset: got %0d pulses first at %0d, expected 1 at %0d", pc_cyc.size(), pc_cyc[0], c0 + 33); end
   endtask

   task automatic test_zero();
      int c0;
      do_reset(); clear_log();
      pulse_start(3'd0, c0);
      vectors++; if (done !== 1'b1 || pc_reset !== 1'b1 || cpu_hold !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_entry: got done=%b pcr=%b hold=%b expected 1 1 0", done, pc_reset, cpu_hold); end
      vectors++; if (bus.byte_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_ready0: got %b expected 0", bus.byte_ready); end
      @(negedge CLK);
      vectors++; if (pc_reset !== 1'b0 || done !== 1'b1 || bus.byte_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL zero_after: got pcr=%b done=%b rdy=%b expected 0 1 0", pc_reset, done, bus.byte_ready); end
      vectors++; if (wr_addr.size() !== 0) begin miscompares++; $display("[TB] FAIL zero_nwrites: got %0d expected 0", wr_addr.size()); end
   endtask

   task automatic test_illegal();
      int c0;
      do_reset(); clear_log();
      pulse_start(3'd5, c0);
      vectors++; if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0 || bus.byte_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL ill_flag: got err=%b hold=%b done=%b rdy=%b expected 1 1 0 0", error, cpu_hold, done, bus.byte_ready); end
      @(negedge CLK);
      vectors++; if (error !== 1'b1 || bus.byte_ready !== 1'b0 || wr_addr.size() !== 0) begin miscompares++; $display("[TB] FAIL ill_stay: got err=%b rdy=%b writes=%0d expected 1 0 0", error, bus.byte_ready, wr_addr.size()); end
      pulse_start(3'd4, c0);
      vectors++; if (error !== 1'b0 || bus.byte_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL ill_clear: got err=%b rdy=%b expected 0 1", error, bus.byte_ready); end
      for (int i = 0; i < 4; i++) send_word(32'h1000_0000 + 32'(i), 0);
      wait_done(20);
      @(negedge CLK);
      vectors++; if (wr_addr.size() !== 4) begin miscompares++; $display("[TB] FAIL full_nwrites: got %0d expected 4", wr_addr.size()); end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (wr_addr[i] !== AW'(i) || wr_data[i] !== 32'h1000_0000 + 32'(i)) begin
            miscompares++; $display("[TB] FAIL full_w%0d: got %h@%h expected %h@%h", i, wr_data[i], wr_addr[i], 32'h1000_0000 + 32'(i), AW'(i));
         end
      end
      vectors++; if (bus.mem_addr !== 2'd3 || done !== 1'b1 || pc_cyc.size() !== 1) begin miscompares++; $display("[TB] FAIL full_end: got addr=%h done=%b pulses=%0d expected 3 1 1", bus.mem_addr, done, pc_cyc.size()); end
   endtask

   task automatic test_reset_mid();
      int c0;
      do_reset(); clear_log();
      pulse_start(3'd2, c0);
      send_word(32'h2008_0001, 0);
      send_byte(8'h20, 0);
      send_byte(8'h08, 0);
      RESET = 1'b1;
      @(negedge CLK);
      vectors++; if (bus.byte_ready !== 1'b0 || bus.mem_we !== 1'b0 || cpu_hold !== 1'b1 || done !== 1'b0 || pc_reset !== 1'b0 || error !== 1'b0) begin miscompares++; $display("[TB] FAIL mid_ctrl: got rdy=%b we=%b hold=%b done=%b pcr=%b err=%b expected 0 0 1 0 0 0", bus.byte_ready, bus.mem_we, cpu_hold, done, pc_reset, error); end
      vectors++; if (bus.mem_addr !== '0 || bus.mem_wdata !== 32'h0) begin miscompares++; $display("[TB] FAIL mid_bus: got %h@%h expected 0@0", bus.mem_wdata, bus.mem_addr); end
      RESET = 1'b0;
      clear_log();
      pulse_start(3'd1, c0);
      send_word(32'hAABB_CCDD, 0);
      wait_done(10);
      @(negedge CLK);
      vectors++; if (wr_addr.size() !== 1 || wr_addr[0] !== 2'd0 || wr_data[0] !== 32'hAABB_CCDD) begin miscompares++; $display("[TB] FAIL mid_reload: got %0d writes, %h@%h expected 1, aabbccdd@0", wr_addr.size(), wr_data[0], wr_addr[0]); end
   endtask

   task automatic test_start_in_recv_and_restart();
      int c0;
      do_reset(); clear_log();
      pulse_start(3'd1, c0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      start = 1'b1; word_count = 3'd3;
      @(negedge CLK);
      start = 1'b0;
      vectors++; if (bus.byte_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL recv_start_rdy: got %b expected 1", bus.byte_ready); end
      send_byte(8'h33, 0);
      send_byte(8'h44, 0);
      wait_done(10);
      @(negedge CLK);
      vectors++; if (wr_addr.size() !== 1 || wr_data[0] !== 32'h1122_3344) begin miscompares++; $display("[TB] FAIL recv_start_write: got %0d writes, %h expected 1, 11223344", wr_addr.size(), wr_data[0]); end
      clear_log();
      pulse_start(3'd1, c0);
      vectors++; if (cpu_hold !== 1'b1 || done !== 1'b0 || pc_reset !== 1'b0) begin miscompares++; $display("[TB] FAIL restart_state: got hold=%b done=%b pcr=%b expected 1 0 0", cpu_hold, done, pc_reset); end
      send_word(32'hCAFE_F00D, 0);
      wait_done(10);
      @(negedge CLK);
      vectors++; if (wr_addr.size() !== 1 || wr_addr[0] !== 2'd0 || wr_data[0] !== 32'hCAFE_F00D) begin miscompares++; $display("[TB] FAIL restart_write: got %0d writes, %h@%h expected 1, cafef00d@0", wr_addr.size(), wr_data[0], wr_addr[0]); end
      vectors++; if (pc_cyc.size() !== 1) begin miscompares++; $display("[TB] FAIL restart_pc_reset: got %0d pulses expected 1", pc_cyc.size()); end
      pulse_start(3'd6, c0);
      vectors++; if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL done_illegal: got err=%b hold=%b done=%b expected 1 1 0", error, cpu_hold, done); end
   endtask

   initial begin
      RESET = 1'b1; start = 1'b0; word_count = '0;
      bus.byte_in = 8'h00; bus.byte_valid = 1'b0;
      @(negedge CLK);
      test_reset();
      test_two_word();
      test_gaps();
      test_zero();
      test_illegal();
      test_reset_mid();
      test_start_in_recv_and_restart();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the CPU instruction-memory interface. The CPU fetches words from instruction memory; this block fills that memory before the CPU runs.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit instruction words. For example, bytes 20 08 00 01 form 32'h2008_0001.
- Writes each word to sequential word addresses and holds the CPU in stall until the programmed word count is loaded. It then releases the CPU with a one-cycle PC-reset pulse.

Parameters:
- ADDR_WIDTH, 10, word-address width of instruction memory. Depth is 2**ADDR_WIDTH words.

Ports:
- CLK  input  1  system clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE or DONE.
- word_count  input  ADDR_WIDTH+1  number of words to load; sampled on the cycle start is accepted.
- byte_in  input  8  stream data byte.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader can accept a byte this cycle.
- mem_we  output  1  instruction-memory write enable.
- mem_addr  output  ADDR_WIDTH  word address of the write.
- mem_wdata  output  32  word being written.
- cpu_hold  output  1  stall CPU fetch/commit while high.
- pc_reset  output  1  one-cycle pulse forcing the CPU PC to 0.
- done  output  1  load complete.
- error  output  1  last start request had an illegal word_count.

Behaviour:
- Clocking and reset:
  - Single clock CLK. RESET is synchronous, active-high, and overrides everything, including a load in progress.
  - Reset values: state=IDLE, byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=1, pc_reset=0, done=0, error=0. The internal byte counter, word counter and latched count are all 0.
- States: IDLE, RECV, WRITE, DONE.
- IDLE:
  - Outputs: cpu_hold=1, byte_ready=0.
  - On start with word_count == 0: go to DONE; pc_reset pulses on entry.
  - On start with word_count > 2**ADDR_WIDTH: error=1, stay in IDLE.
  - On start otherwise: latch the count, clear error, go to RECV.
- RECV:
  - Outputs: byte_ready=1, cpu_hold=1.
  - A byte transfers on byte_valid && byte_ready. Each transfer shifts byte_in into the word: first byte to [31:24], second to [23:16], third to [15:8], fourth to [7:0].
  - When byte_valid is low: hold all state; any number of idle cycles is allowed.
  - The 4th accepted byte moves the FSM to WRITE on the next edge.
  - start is ignored.
- WRITE (exactly one cycle):
  - Outputs: mem_we=1, mem_addr = current word index, mem_wdata = assembled word, byte_ready=0.
  - Next edge: increment the word index. If the new index equals the latched count, go to DONE; otherwise go to RECV.
- DONE:
  - On entry, pc_reset=1 for exactly one cycle (the first DONE cycle). In that cycle cpu_hold=0, done=1 and byte_ready=0; done and cpu_hold=0 persist thereafter.
  - start re-enters the IDLE start evaluation in the same cycle: cpu_hold returns to 1 next cycle, done clears, and the index resets to 0.
  - An illegal word_count on a start in DONE sets error=1, returns to IDLE, and leaves cpu_hold=1.
- Other rules:
  - mem_we is high only in WRITE. mem_addr and mem_wdata hold their last values otherwise.
  - Load throughput is at most 1 word per 5 cycles.
  - The word index never wraps: a count of 2**ADDR_WIDTH ends at the last address, then goes to DONE.
  - Bytes presented outside RECV are not accepted (byte_ready=0) and are not consumed.

Test Plan:
- Two-word load:
  - Stimulus: RESET 2 cycles; start with word_count=2; bytes 20 08 00 01 20 08 00 02 presented back-to-back with valid held high.
  - Response: mem_we at addr 0 with 32'h2008_0001, then addr 1 with 32'h2008_0002. Then one pc_reset pulse, done=1, cpu_hold=0. Total 10 cycles from start acceptance to DONE entry.
- Backpressure and gaps:
  - Stimulus: same stream with byte_valid deasserted for 3 random cycles between bytes.
  - Response: identical writes; no byte lost or duplicated; write timing shifts by the gap cycles.
- Zero-length load:
  - Stimulus: start with word_count=0.
  - Response: no mem_we; DONE next cycle with pc_reset pulse; byte_ready stays 0.
- Illegal count:
  - Stimulus: ADDR_WIDTH=2, start with word_count=5.
  - Response: error=1, state stays IDLE, cpu_hold=1, no writes.
  - Follow-up: start with word_count=4.
  - Response: error clears; 4 writes to addr 0..3; DONE with no wrap.
- Reset mid-load:
  - Stimulus: assert RESET after 6 bytes of a 2-word load.
  - Response: next cycle all outputs at reset values and the partial word is discarded.
  - Follow-up: a new start with word_count=1 and bytes AA BB CC DD.
  - Response: write 32'hAABB_CCDD at addr 0.
- Start in RECV / restart from DONE:
  - Stimulus: pulse start during RECV.
  - Response: ignored.
  - Stimulus: pulse start in DONE with word_count=1.
  - Response: cpu_hold=1 and done=0 next cycle; the reload writes addr 0; a fresh pc_reset pulse follows.
